// File: rtl/moore_fsm_pkg.sv
// ---------------------------------------------------------------------------
// moore_fsm_pkg
// Shared definitions for the 1-0-1 serial pattern detector:
//   - state_t   : 2-bit state enumeration S0..S3
//   - ENC_S*    : raw encoding constants for the four states
//   - is_detect : decode of the detect state
// ---------------------------------------------------------------------------
package moore_fsm_pkg;

   localparam logic [1:0] ENC_S0 = 2'd0;   // idle
   localparam logic [1:0] ENC_S1 = 2'd1;   // seen "1"
   localparam logic [1:0] ENC_S2 = 2'd2;   // seen "10"
   localparam logic [1:0] ENC_S3 = 2'd3;   // seen "101"

   typedef enum logic [1:0] {
      S0 = ENC_S0,
      S1 = ENC_S1,
      S2 = ENC_S2,
      S3 = ENC_S3
   } state_t;

   // True when the given state is the pattern-complete state.
   function automatic logic is_detect(input state_t s);
      return (s == S3) ? 1'b1 : 1'b0;
   endfunction

endpackage : moore_fsm_pkg

// File: rtl/moore_fsm_counter.sv
// ---------------------------------------------------------------------------
// moore_fsm_counter
// Saturating up-counter of pattern detections.
// Ports:
//   clk   - clock, rising edge
//   rst   - asynchronous active-low reset, clears count
//   inc   - increment request for this edge
//   count - current count, holds at all-ones once reached
// ---------------------------------------------------------------------------
module moore_fsm_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   // Count register: increments on request, sticks at CNT_MAX instead of wrapping.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= {CNT_W{1'b0}};
      end else if (inc && (count != CNT_MAX)) begin
         count <= count + CNT_ONE;
      end else begin
         count <= count;
      end
   end

endmodule : moore_fsm_counter

// File: rtl/moore_fsm.sv
// ---------------------------------------------------------------------------
// moore_fsm
// Moore FSM detecting the serial pattern 1-0-1 on 'in'.
// Parameters:
//   OVERLAP - 1: the final 1 of a match may start the next match
//             0: a new match must use only bits after the previous match
//   CNT_W   - width of the detection counter
// Ports:
//   clk         - clock, rising edge
//   rst         - asynchronous active-low reset
//   in          - serial data bit
//   out         - detect flag, high while in S3 (registered, no path from in)
//   state_o     - current state encoding (debug)
//   match_count - saturating number of detections since reset
// ---------------------------------------------------------------------------
module moore_fsm
   import moore_fsm_pkg::*;
#(
   parameter bit OVERLAP = 1'b1,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in,
   output logic             out,
   output logic [1:0]       state_o,
   output logic [CNT_W-1:0] match_count
);

   state_t state;
   state_t next_state;
   logic   enter_detect;

   // Next-state logic for the 1-0-1 detector.
   always_comb begin
      next_state = S0;
      case (state)
         S0: begin
            if (in) next_state = S1;
            else    next_state = S0;
         end
         S1: begin
            if (in) next_state = S1;
            else    next_state = S2;
         end
         S2: begin
            if (in) next_state = S3;
            else    next_state = S0;
         end
         S3: begin
            // With overlap the trailing 1 already counts as "1", so a 0 means "10".
            if (in)           next_state = S1;
            else if (OVERLAP) next_state = S2;
            else              next_state = S0;
         end
         default: begin
            next_state = S0;
         end
      endcase
   end

   // State register with the detect flag registered alongside it, so out always
   // equals (state == S3) without any combinational path from in.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S0;
         out   <= 1'b0;
      end else begin
         state <= next_state;
         out   <= is_detect(next_state);
      end
   end

   // S3 never loops to itself, so every edge whose next state is S3 is an entry.
   assign enter_detect = is_detect(next_state);
   assign state_o      = state;

   moore_fsm_counter #(
      .CNT_W (CNT_W)
   ) u_counter (
      .clk   (clk),
      .rst   (rst),
      .inc   (enter_detect),
      .count (match_count)
   );

endmodule : moore_fsm

// File: tb/tb_moore_fsm.sv
// ---------------------------------------------------------------------------
// tb_moore_fsm
// Three detector instances share clk/rst/in:
//   dut_ov : OVERLAP=1, CNT_W=16
//   dut_no : OVERLAP=0, CNT_W=16
//   dut_sat: OVERLAP=1, CNT_W=2 (saturation)
// Expected values come from a bit-history model: a match is the last three
// bits of the current segment reading 1,0,1; in non-overlap mode the segment
// restarts after each match. Reset clears all segments.
// ---------------------------------------------------------------------------
module tb_moore_fsm;

   logic        clk;
   logic        rst;
   logic        in;

   logic        out_ov, out_no, out_sat;
   logic [1:0]  st_ov, st_no, st_sat;
   logic [15:0] mc_ov, mc_no;
   logic [1:0]  mc_sat;

   int n_tests;
   int n_fail;

   // Reference model state
   bit seg_ov[$];
   bit seg_no[$];
   int exp_st_ov;
   int exp_st_no;
   int cnt_ov;
   int cnt_no;

   moore_fsm #(.OVERLAP(1'b1), .CNT_W(16)) dut_ov (
      .clk(clk), .rst(rst), .in(in),
      .out(out_ov), .state_o(st_ov), .match_count(mc_ov));

   moore_fsm #(.OVERLAP(1'b0), .CNT_W(16)) dut_no (
      .clk(clk), .rst(rst), .in(in),
      .out(out_no), .state_o(st_no), .match_count(mc_no));

   moore_fsm #(.OVERLAP(1'b1), .CNT_W(2)) dut_sat (
      .clk(clk), .rst(rst), .in(in),
      .out(out_sat), .state_o(st_sat), .match_count(mc_sat));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Progress of the detector after the bits of one segment: 3 on a fresh
   // 1-0-1, 2 when the segment ends in 1-0, 1 when it ends in 1, else 0.
   function automatic int classify(input bit q[$]);
      int n;
      n = q.size();
      if (n >= 3 && q[n-3] == 1'b1 && q[n-2] == 1'b0 && q[n-1] == 1'b1) return 3;
      if (n >= 2 && q[n-2] == 1'b1 && q[n-1] == 1'b0) return 2;
      if (n >= 1 && q[n-1] == 1'b1) return 1;
      return 0;
   endfunction

   task automatic model_reset();
      seg_ov.delete();
      seg_no.delete();
      exp_st_ov = 0;
      exp_st_no = 0;
      cnt_ov    = 0;
      cnt_no    = 0;
   endtask

   task automatic model_bit(input bit b);
      seg_ov.push_back(b);
      if (seg_ov.size() > 3) void'(seg_ov.pop_front());
      exp_st_ov = classify(seg_ov);
      if (exp_st_ov == 3) cnt_ov++;
      seg_no.push_back(b);
      exp_st_no = classify(seg_no);
      if (exp_st_no == 3) begin
         cnt_no++;
         seg_no.delete();
      end
   endtask

   task automatic check_all(input string tag);
      int sat;
      sat = (cnt_ov > 3) ? 3 : cnt_ov;
      check({tag, ".ov.out"},   {15'd0, out_ov},  (exp_st_ov == 3) ? 16'd1 : 16'd0);
      check({tag, ".ov.state"}, {14'd0, st_ov},   16'(exp_st_ov));
      check({tag, ".ov.count"}, mc_ov,            16'(cnt_ov));
      check({tag, ".no.out"},   {15'd0, out_no},  (exp_st_no == 3) ? 16'd1 : 16'd0);
      check({tag, ".no.state"}, {14'd0, st_no},   16'(exp_st_no));
      check({tag, ".no.count"}, mc_no,            16'(cnt_no));
      check({tag, ".sat.out"},  {15'd0, out_sat}, (exp_st_ov == 3) ? 16'd1 : 16'd0);
      check({tag, ".sat.count"},{14'd0, mc_sat},  16'(sat));
   endtask

   // One clock: drive at the falling edge, check just after the rising edge.
   task automatic step(input bit b, input string tag);
      @(negedge clk);
      in = b;
      @(posedge clk);
      #1;
      model_bit(b);
      check_all(tag);
   endtask

   // Assert reset at a falling edge, check immediately, hold two cycles with
   // in toggling, release at a falling edge.
   task automatic hold_reset(input string tag);
      @(negedge clk);
      rst = 1'b0;
      #1;
      model_reset();
      check_all({tag, ".imm"});
      for (int c = 0; c < 2; c++) begin
         @(posedge clk);
         #1;
         check_all({tag, ".hold"});
         @(negedge clk);
         in = ~in;
      end
      rst = 1'b1;
   endtask

   // Short reset pulse between clock edges, never seeing a rising edge.
   task automatic pulse_reset(input string tag);
      #1 rst = 1'b0;
      #1;
      model_reset();
      check_all(tag);
      #1 rst = 1'b1;
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst     = 1'b0;
      in      = 1'b0;
      model_reset();

      #1;
      check_all("por");
      hold_reset("rst0");

      // Basic detection: 1,0,1
      step(1'b1, "basic1");
      step(1'b0, "basic2");
      step(1'b1, "basic3");
      step(1'b0, "basic4");
      hold_reset("rst1");

      // Overlap vs non-overlap: 1,0,1,0,1
      step(1'b1, "ovl1");
      step(1'b0, "ovl2");
      step(1'b1, "ovl3");
      step(1'b0, "ovl4");
      step(1'b1, "ovl5");
      step(1'b1, "ovl6");
      hold_reset("rst2");

      // Mid-sequence async reset discards progress: 1,0,<rst>,1
      step(1'b1, "mid1");
      step(1'b0, "mid2");
      pulse_reset("midrst");
      step(1'b1, "mid3");
      step(1'b0, "mid4");
      hold_reset("rst3");

      // Leading repeated 1: 1,1,0,1
      step(1'b1, "lead1");
      step(1'b1, "lead2");
      step(1'b0, "lead3");
      step(1'b1, "lead4");
      hold_reset("rst4");

      // Five overlapping detections saturate the 2-bit counter.
      step(1'b1, "satA");
      for (int k = 0; k < 5; k++) begin
         step(1'b0, "sat0");
         step(1'b1, "sat1");
      end
      step(1'b0, "satZ");

      // Random bits with occasional asynchronous reset pulses.
      for (int k = 0; k < 400; k++) begin
         step(1'($urandom_range(1, 0)), "rnd");
         if ($urandom_range(39, 0) == 0) pulse_reset("rndrst");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_moore_fsm

// File: doc/moore_fsm.md
MOORE_FSM -- requirements
Module: moore_fsm

Interface
REQ-001 Parameter OVERLAP, default 1, meaning 1 = overlapping detection and 0 = non-overlapping.
REQ-002 Parameter CNT_W, default 16, meaning width of the detection counter.
REQ-003 Port clk, input, 1, sole clock; all state updates on rising edge.
REQ-004 Port rst, input, 1, reset; asynchronous, active-low.
REQ-005 Port in, input, 1, serial data bit, sampled on each rising clk edge.
REQ-006 Port out, output, 1, Moore detect flag; high while FSM is in state S3.
REQ-007 Port state_o, output, 2, current state encoding, for debug.
REQ-008 Port match_count, output, CNT_W, saturating count of detections since reset.

Function
REQ-009 The block SHALL detect the serial pattern 1-0-1 on in as a 4-state Moore FSM: S0=2'd0 (idle), S1=2'd1 (got "1"), S2=2'd2 (got "10"), S3=2'd3 (got "101").
REQ-010 S0 transitions: in=1 -> S1; in=0 -> S0.
REQ-011 S1 transitions: in=1 -> S1; in=0 -> S2.
REQ-012 S2 transitions: in=1 -> S3; in=0 -> S0.
REQ-013 S3 with OVERLAP=1: in=1 -> S1; in=0 -> S2, so the trailing 1 is reused.
REQ-014 S3 with OVERLAP=0: in=1 -> S1; in=0 -> S0.
REQ-015 out SHALL be a function of the state register only (out = state==S3), with no combinational path from in.
REQ-016 out SHALL rise in the cycle following the rising edge that samples the final 1, and SHALL stay high for exactly one cycle unless a new detection follows.
REQ-017 match_count SHALL increment by 1 on each edge that enters S3.
REQ-018 match_count SHALL saturate at all-ones and SHALL NOT wrap.
REQ-019 state_o SHALL equal the state register.
REQ-020 Illegal encodings cannot occur with a 2-bit, 4-state encoding; the default branch of the next-state logic SHALL go to S0.

Reset
REQ-021 While rst=0, the state SHALL be S0, out SHALL be 0, state_o SHALL be 2'd0 and match_count SHALL be 0, immediately and without waiting for a clk edge.
REQ-022 Asserting rst mid-sequence SHALL discard all partial progress; detection restarts from S0 after release.
REQ-023 The first rising edge after rst goes high SHALL sample in normally.

Structure
REQ-024 Package moore_fsm_pkg SHALL hold the state typedef (2-bit enum S0..S3) and the encoding constants.
REQ-025 The saturating counter SHALL be one sub-module, moore_fsm_counter (parameter CNT_W; inputs clk, rst, inc; output count).
REQ-026 The state register, next-state logic and output decode SHALL live in moore_fsm itself.

Verification
REQ-027 Reset scenario: hold rst=0 for 2 cycles with in toggling -> out=0, state_o=0, match_count=0 throughout.
REQ-028 Basic detection: in=1,0,1 on edges 1-3 -> out=1 only in the cycle after edge 3, and match_count=1.
REQ-029 Overlap detection: in=1,0,1,0,1 with OVERLAP=1 -> out high after edges 3 and 5, and match_count=2.
REQ-030 Non-overlap detection: same stimulus with OVERLAP=0 -> out high after edge 3 only, and match_count=1.
REQ-031 Reset mid-sequence and leading-1 handling: in=1,0, then pulse rst=0 asynchronously, then in=1 -> no detect. Separately, in=1,1,0,1 -> out high after edge 4.
REQ-032 Counter saturation: with CNT_W=2, apply 5 consecutive detections -> match_count holds at 3.
